// File: rtl/add6_rr_sched_if.sv
// Request/response bundle between the requesters and the shared-adder scheduler.
interface add6_rr_sched_if #(
  parameter int unsigned WIDTH = 24
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin0;
  logic             cin1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1,
    input  gnt, busy, done, done_id, sum, cout
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1,
    output gnt, busy, done, done_id, sum, cout
  );
endinterface

// File: rtl/add6_rr_sched.sv
// Round-robin arbiter that runs a 24-bit add through one 6-bit adder slice,
// one chunk per cycle, least significant chunk first.
module add6_rr_sched #(
  parameter int unsigned CHUNKS = 4
) (
  input logic           clk,
  input logic           rst_n,
  add6_rr_sched_if.slave bus
);

  localparam int unsigned W    = 6 * CHUNKS;
  localparam int unsigned CntW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            done_id_q, done_id_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            pick;
  logic [6:0]      chunk;

  // The shared slice: carry_q holds cin for chunk 0, then the rippled carry.
  assign chunk = {1'b0, a_q[6*cnt_q +: 6]} + {1'b0, b_q[6*cnt_q +: 6]} + {6'd0, carry_q};

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    acc_d     = acc_q;
    pick      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester not served last wins.
          pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          gnt_d   = pick ? 2'b10 : 2'b01;
          last_d  = pick;
          a_d     = pick ? bus.a1 : bus.a0;
          b_d     = pick ? bus.b1 : bus.b0;
          carry_d = pick ? bus.cin1 : bus.cin0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d[6*cnt_q +: 6] = chunk[5:0];
        carry_d             = chunk[6];
        cnt_d               = cnt_q + 1'b1;
        if (cnt_q == CntW'(CHUNKS - 1)) begin
          sum_d     = acc_d;
          cout_d    = chunk[6];
          done_id_d = gnt_q[1];
          done_d    = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b0;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      acc_q     <= acc_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;

endmodule

// File: tb/tb_add6_rr_sched.sv
// Directed bench for add6_rr_sched with a queue of expected completions.
module tb_add6_rr_sched;

  logic clk;
  logic rst_n;

  add6_rr_sched_if #(.WIDTH(24)) bus ();

  add6_rr_sched #(.CHUNKS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        id;
    logic [23:0] sum;
    logic        cout;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [23:0] last_sum = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [23:0] s, input logic c);
    exp_t e;
    e.id   = id;
    e.sum  = s;
    e.cout = c;
    sb.push_back(e);
  endtask

  // Waits on falling edges for done; checks latency, then the scoreboard head.
  task automatic run_done(input string tag, input int exp_lat, input bit drop);
    int   n = 0;
    bit   found = 0;
    exp_t e;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) found = 1;
      else check({tag, "_sum_hold"}, 32'(bus.sum), 32'(last_sum));
    end
    check({tag, "_latency"}, found ? n : -1, exp_lat);
    if (found && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_done_id"}, 32'(bus.done_id), 32'(e.id));
      check({tag, "_sum"}, 32'(bus.sum), 32'(e.sum));
      check({tag, "_cout"}, 32'(bus.cout), 32'(e.cout));
      check({tag, "_gnt"}, 32'(bus.gnt), e.id ? 32'd2 : 32'd1);
      last_sum = e.sum;
      if (drop) begin
        if (e.id) bus.req1 = 1'b0;
        else bus.req0 = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    last_sum = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = '0;
    bus.b0   = '0;
    bus.a1   = '0;
    bus.b1   = '0;
    bus.cin0 = 1'b0;
    bus.cin1 = 1'b0;
    do_reset();
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_done_id", 32'(bus.done_id), 0);
    check("rst_sum", 32'(bus.sum), 0);
    check("rst_cout", 32'(bus.cout), 0);

    // Single request, full ripple through every chunk.
    bus.req0 = 1'b1;
    bus.a0   = 24'hFFFFFF;
    bus.b0   = 24'h000001;
    bus.cin0 = 1'b0;
    push(1'b0, 24'h000000, 1'b1);
    @(negedge clk);
    check("t1_gnt", 32'(bus.gnt), 1);
    check("t1_busy", 32'(bus.busy), 1);
    run_done("t1", 4, 1);
    @(negedge clk);
    check("t1_idle_gnt", 32'(bus.gnt), 0);
    check("t1_idle_busy", 32'(bus.busy), 0);
    check("t1_idle_done", 32'(bus.done), 0);
    check("t1_hold_sum", 32'(bus.sum), 0);
    check("t1_hold_cout", 32'(bus.cout), 1);

    // Carry-in propagating out of chunk 0.
    bus.req1 = 1'b1;
    bus.a1   = 24'h00003F;
    bus.b1   = 24'h000000;
    bus.cin1 = 1'b1;
    push(1'b1, 24'h000040, 1'b0);
    @(negedge clk);
    check("t2_gnt", 32'(bus.gnt), 2);
    run_done("t2", 4, 1);
    @(negedge clk);

    // Simultaneous requests straight after reset: requester 0 first.
    do_reset();
    bus.req0 = 1'b1;
    bus.a0   = 24'h000010;
    bus.b0   = 24'h000020;
    bus.cin0 = 1'b0;
    bus.req1 = 1'b1;
    bus.a1   = 24'h100000;
    bus.b1   = 24'h100000;
    bus.cin1 = 1'b0;
    push(1'b0, 24'h000030, 1'b0);
    push(1'b1, 24'h200000, 1'b0);
    @(negedge clk);
    check("t3_gnt", 32'(bus.gnt), 1);
    run_done("t3a", 4, 1);
    run_done("t3b", 6, 1);

    // Both requests held: grants alternate 0,1,0,1.
    bus.req0 = 1'b1;
    bus.a0   = 24'h123456;
    bus.b0   = 24'h111111;
    bus.cin0 = 1'b1;
    bus.req1 = 1'b1;
    bus.a1   = 24'hFFFF00;
    bus.b1   = 24'h000100;
    bus.cin1 = 1'b1;
    push(1'b0, 24'h234568, 1'b0);
    push(1'b1, 24'h000001, 1'b1);
    push(1'b0, 24'h234568, 1'b0);
    push(1'b1, 24'h000001, 1'b1);
    run_done("t4a", 6, 0);
    run_done("t4b", 6, 0);
    run_done("t4c", 6, 0);
    run_done("t4d", 6, 0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);

    // Operands altered after the grant must not affect the result.
    bus.req0 = 1'b1;
    bus.a0   = 24'h000001;
    bus.b0   = 24'h000001;
    bus.cin0 = 1'b0;
    push(1'b0, 24'h000002, 1'b0);
    @(negedge clk);
    check("t5_gnt", 32'(bus.gnt), 1);
    bus.a0 = 24'hFFFFFF;
    bus.b0 = 24'hFFFFFF;
    run_done("t5", 4, 1);
    @(negedge clk);

    // Reset in the middle of RUN abandons the transaction.
    bus.req0 = 1'b1;
    bus.a0   = 24'h000005;
    bus.b0   = 24'h000007;
    repeat (3) @(negedge clk);
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    #1;
    check("t6_rst_gnt", 32'(bus.gnt), 0);
    check("t6_rst_busy", 32'(bus.busy), 0);
    check("t6_rst_done", 32'(bus.done), 0);
    check("t6_rst_sum", 32'(bus.sum), 0);
    check("t6_rst_cout", 32'(bus.cout), 0);
    last_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_done", 32'(bus.done), 0);
    end
    bus.req0 = 1'b1;
    bus.a0   = 24'h0F0F0F;
    bus.b0   = 24'h010101;
    bus.cin0 = 1'b1;
    push(1'b0, 24'h101011, 1'b0);
    @(negedge clk);
    check("t6_gnt", 32'(bus.gnt), 1);
    run_done("t6", 4, 1);
    @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/add6_rr_sched.md
# add6_rr_sched

Round-robin scheduler that shares a single 6-bit add slice (a, b and carry-in produce a 6-bit sum and a carry-out) between two requesters. Each requester submits a 24-bit add with carry-in. The block captures the operands and runs the addition through the slice in four 6-bit chunks, least significant first, rippling the carry between chunks. It sits between the project's requester logic and the shared adder slice.

## Interface
- CHUNKS, 4: number of 6-bit chunks per operation. Operand width is 6*CHUNKS = 24.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request from requester 0 / 1.
- a0, b0 / a1, b1  in  24  operands for requester 0 / 1.
- cin0 / cin1  in  1  carry-in for requester 0 / 1.
- gnt  out  2  one-hot grant; bit i means requester i is being served. 00 when idle.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse; the result is valid.
- done_id  out  1  requester index the current result belongs to.
- sum  out  24  result, taken mod 2^24.
- cout  out  1  carry out of the top chunk.

## Operation
- The state machine has three states: IDLE, RUN and DONE. All outputs are registered.
- **Reset values:** state=IDLE, gnt=00, busy=0, done=0, done_id=0, sum=0, cout=0, chunk counter=0, last_served=1. With last_served=1, requester 0 wins the first tie.
- **IDLE:** if any req is high, grant one requester.
  - Tie: grant the requester that is NOT last_served.
  - Single request: grant that requester.
  - On grant: capture its a, b and cin into internal registers, set gnt, update last_served, counter=0, go to RUN.
- **RUN:** each cycle, add chunk k of the captured a and b plus the carry (cin for k=0).
  - Store the 6-bit result into the accumulator bits [6k+5:6k] and register the carry-out.
  - k increments each cycle. At k=CHUNKS-1, go to DONE.
  - Captured operands are used throughout, so requester inputs may change freely after the grant.
- **Completion (the edge entering DONE):** sum is loaded from the accumulator, cout from the final carry, done_id from the grant. These are the only updates to sum and cout.
- **DONE:** done=1 for exactly one cycle. On the next edge: gnt=00, go to IDLE. DONE never samples requests.
- **Handshake:** a requester holds req until it sees done with a matching done_id, then drops req on the next edge. A req still high at the next IDLE sampling edge counts as a new request.
- **Hold:** sum, cout and done_id keep their values until the next completion.
- **Reset mid-operation:** the transaction is abandoned, no done is produced, and every output returns to its reset value.
- **Starvation freedom:** with both reqs held continuously, grants strictly alternate.

## Timing
- E0 is the IDLE edge that samples req.
  - After E0: gnt and busy are high.
  - E1..E4: chunks 0..3 are computed, one per edge.
  - After E4: done=1 and sum/cout are valid.
  - After E5: IDLE, gnt=00, busy=0, done=0.
- The earliest next grant is at E6, giving a back-to-back period of 6 cycles.
- Request to done latency: 5 edges (E0..E4).
- sum/cout change only at completion edges and are stable in every other cycle, including during RUN.
- Requests arriving during RUN or DONE wait; they are sampled at the first IDLE edge.

## Test plan
- **Single request, full ripple:** req0 only, a0=0xFFFFFF, b0=0x000001, cin0=0.
  - Response: gnt=01 after E0, done after E4 with sum=0x000000, cout=1, done_id=0.
- **Chunk carry-in:** req1 only, a1=0x00003F, b1=0, cin1=1.
  - Response: sum=0x000040, cout=0, done_id=1, gnt=10.
- **Simultaneous requests after reset:** req0 (0x000010+0x000020) and req1 (0x100000+0x100000) raised together.
  - Response: first done_id=0 with sum=0x000030.
  - Then done_id=1 with sum=0x200000, cout=0, 6 cycles after the first done.
- **Round-robin fairness:** both reqs held high for 4 transactions.
  - Response: done_id sequence 0,1,0,1; busy never high for one requester twice in a row.
- **Operands change after grant:** a0=0x000001, b0=0x000001 at E0, then changed to 0xFFFFFF at E1.
  - Response: sum=0x000002, cout=0.
- **Reset mid-RUN:** assert rst_n=0 after E2.
  - Response: immediately gnt=00, busy=0, done=0, sum=0, cout=0; no done after release.
  - A subsequent req0 completes normally.
